// File: rtl/mac_dot_seq_pkg.sv
// Shared types and constants for the dot-product MAC sequencer.
package mac_dot_seq_pkg;

  localparam int unsigned OPND_W         = 8;
  localparam int unsigned MAC_PIPE_DRAIN = 2;
  localparam int unsigned DRAIN_CNT_W    = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mac_dot_seq.sv
// Dot-product initiator: fetches operand pairs from two sync-read RAMs,
// streams them into an external 8x8->RES_W MAC, drains its 2-stage product
// pipeline and offers the accumulator on a valid/ready result port.
// Optional feature: define MAC_DOT_SEQ_BIAS_EN to add a bias port whose
// value (sampled with start) preloads the accumulator instead of zero.
module mac_dot_seq
  import mac_dot_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 9,
  parameter int unsigned RES_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic [ADDR_W-1:0]        base_a,
  input  logic [ADDR_W-1:0]        base_b,
  output logic                     busy,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        a_addr,
  output logic [ADDR_W-1:0]        b_addr,
  input  logic [OPND_W-1:0]        a_rdata,
  input  logic [OPND_W-1:0]        b_rdata,
  output logic                     mac_en,
  output logic                     mac_acc_load,
  output logic [OPND_W-1:0]        mac_x,
  output logic [OPND_W-1:0]        mac_y,
  output logic [RES_W-1:0]         mac_z,
`ifdef MAC_DOT_SEQ_BIAS_EN
  input  logic [RES_W-1:0]         bias,
`endif
  input  logic [RES_W-1:0]         mac_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [RES_W-1:0]         res_data
);

  localparam int unsigned CNT_W = LEN_W + 1;

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        len_q;
  logic [ADDR_W-1:0]       base_a_q, base_b_q;
  logic [LEN_W-1:0]        r_q, r_d;
  logic [DRAIN_CNT_W-1:0]  drain_q, drain_d;

  logic                    busy_d, rd_en_d, mac_en_d, mac_acc_load_d, res_valid_d;
  logic [ADDR_W-1:0]       a_addr_d, b_addr_d;
  logic [RES_W-1:0]        mac_z_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, counters and next-cycle output values decoded from the next state
  always_comb begin
    state_d        = state_q;
    r_d            = r_q;
    drain_d        = drain_q;
    busy_d         = 1'b1;
    rd_en_d        = 1'b0;
    a_addr_d       = a_addr;
    b_addr_d       = b_addr;
    mac_en_d       = 1'b0;
    mac_acc_load_d = 1'b0;
    mac_z_d        = '0;
    res_valid_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        r_d     = '0;
        drain_d = '0;
        state_d = (len_q != '0) ? RUN : DRAIN;
      end
      RUN: begin
        if (CNT_W'(r_q) + CNT_W'(1) == CNT_W'(len_q)) state_d = DRAIN;
        else                                         r_d     = r_q + LEN_W'(1);
      end
      DRAIN: begin
        if (drain_q == DRAIN_CNT_W'(MAC_PIPE_DRAIN - 1)) state_d = DONE;
        else                                            drain_d = drain_q + DRAIN_CNT_W'(1);
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      IDLE: busy_d = 1'b0;
      LOAD: begin
        rd_en_d        = 1'b1;
        a_addr_d       = base_a;
        b_addr_d       = base_b;
        mac_en_d       = 1'b1;
        mac_acc_load_d = 1'b1;
`ifdef MAC_DOT_SEQ_BIAS_EN
        mac_z_d        = bias;
`else
        mac_z_d        = '0;
`endif
      end
      RUN: begin
        mac_en_d = 1'b1;
        // Prefetch pair r+1 while pair r is consumed; no read past the last pair
        if (CNT_W'(r_d) + CNT_W'(1) < CNT_W'(len_q)) begin
          rd_en_d  = 1'b1;
          a_addr_d = base_a_q + ADDR_W'(r_d) + ADDR_W'(1);
          b_addr_d = base_b_q + ADDR_W'(r_d) + ADDR_W'(1);
        end
      end
      DRAIN: mac_en_d = 1'b1;
      DONE:  res_valid_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  // Job parameters, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q        <= '0;
      base_a_q     <= '0;
      base_b_q     <= '0;
      r_q          <= '0;
      drain_q      <= '0;
      busy         <= 1'b0;
      rd_en        <= 1'b0;
      a_addr       <= '0;
      b_addr       <= '0;
      mac_en       <= 1'b0;
      mac_acc_load <= 1'b0;
      mac_z        <= '0;
      res_valid    <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        len_q    <= len;
        base_a_q <= base_a;
        base_b_q <= base_b;
      end
      r_q          <= r_d;
      drain_q      <= drain_d;
      busy         <= busy_d;
      rd_en        <= rd_en_d;
      a_addr       <= a_addr_d;
      b_addr       <= b_addr_d;
      mac_en       <= mac_en_d;
      mac_acc_load <= mac_acc_load_d;
      mac_z        <= mac_z_d;
      res_valid    <= res_valid_d;
    end
  end

  // RAM read data arrives one cycle after rd_en, exactly when RUN consumes it
  assign mac_x    = (state_q == RUN) ? a_rdata : '0;
  assign mac_y    = (state_q == RUN) ? b_rdata : '0;
  // Accumulator is frozen in DONE, so the result is stable while waiting for ready
  assign res_data = res_valid ? mac_result : '0;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Self-checking bench for mac_dot_seq with behavioural operand RAMs and MAC.
module tb_mac_dot_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  len;
  logic [7:0]  base_a, base_b;
  logic        busy, rd_en;
  logic [7:0]  a_addr, b_addr;
  logic [7:0]  a_rdata, b_rdata;
  logic        mac_en, mac_acc_load;
  logic [7:0]  mac_x, mac_y;
  logic [31:0] mac_z;
  logic [31:0] bias;
  logic [31:0] mac_result;
  logic        res_valid, res_ready;
  logic [31:0] res_data;

  always #5 clk = ~clk;

  mac_dot_seq dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .base_a(base_a), .base_b(base_b), .busy(busy), .rd_en(rd_en),
    .a_addr(a_addr), .b_addr(b_addr), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mac_en(mac_en), .mac_acc_load(mac_acc_load), .mac_x(mac_x), .mac_y(mac_y),
    .mac_z(mac_z),
`ifdef MAC_DOT_SEQ_BIAS_EN
    .bias(bias),
`endif
    .mac_result(mac_result), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data)
  );

  // Sync-read operand RAMs
  logic [7:0] ram_a [256];
  logic [7:0] ram_b [256];
  always @(posedge clk) begin
    if (rd_en) begin
      a_rdata <= ram_a[a_addr];
      b_rdata <= ram_b[b_addr];
    end
  end

  // MAC: product register, second pipeline stage, accumulator
  logic signed [15:0] p1, p2;
  logic signed [31:0] acc;
  always @(posedge clk) begin
    if (rst) begin
      p1 <= '0; p2 <= '0; acc <= '0;
    end else if (mac_en) begin
      p1 <= $signed(mac_x) * $signed(mac_y);
      if (mac_acc_load) begin
        p2  <= '0;
        acc <= $signed(mac_z);
      end else begin
        p2  <= p1;
        acc <= acc + 32'(p2);
      end
    end
  end
  assign mac_result = acc;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: expected results queued at launch, compared on handshake
  int sb_q[$];
  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      if (sb_q.size() == 0) chk("sb_unexpected_result", 1, 0);
      else chk("sb_result", int'($signed(res_data)), sb_q.pop_front());
    end
  end

  // Read-address log
  int aq[$];
  int bq[$];
  always @(negedge clk) begin
    if (rd_en) begin
      aq.push_back(int'(a_addr));
      bq.push_back(int'(b_addr));
    end
  end

  typedef struct packed {
    logic [8:0]       len;
    logic [7:0]       base_a;
    logic [7:0]       base_b;
    logic [31:0]      bias;
    logic [3:0][7:0]  a;
    logic [3:0][7:0]  b;
    logic [31:0]      exp_nb;
    logic [31:0]      exp_b;
    logic [3:0]       hold;
  } vec_t;

  vec_t vecs[5];

  task automatic run_job(input logic [8:0] l, input logic [7:0] ba, input logic [7:0] bb,
                         input logic [31:0] bi, input logic [3:0][7:0] av,
                         input logic [3:0][7:0] bv, input logic [31:0] exp, input int hold);
    int cnt;
    for (int i = 0; i < int'(l) && i < 4; i++) begin
      ram_a[8'(int'(ba) + i)] = av[i];
      ram_b[8'(int'(bb) + i)] = bv[i];
    end
    aq.delete(); bq.delete();
    @(posedge clk); #1;
    start = 1'b1; len = l; base_a = ba; base_b = bb; bias = bi;
    sb_q.push_back(int'(exp));
    @(posedge clk); #1;
    start = 1'b0; len = '0;
    chk("load_busy", int'(busy), 1);
    chk("load_acc_load", int'(mac_acc_load), 1);
    chk("load_rd_en", int'(rd_en), 1);
    cnt = 0;
    while (!res_valid && cnt < 600) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("latency", cnt, int'(l) + 3);
    chk("done_mac_en", int'(mac_en), 0);
    chk("rd_count", aq.size(), (l == 0) ? 1 : int'(l));
    for (int k = 0; k < hold; k++) begin
      start = ~start; len = 9'd1;
      @(posedge clk); #1;
      chk("hold_valid", int'(res_valid), 1);
      chk("hold_data", int'($signed(res_data)), int'(exp));
    end
    start = 1'b0; len = '0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("after_busy", int'(busy), 0);
    chk("after_valid", int'(res_valid), 0);
    @(posedge clk); #1;
    chk("idle_stays", int'(busy), 0);
  endtask

  initial begin
    logic [3:0][7:0] av, bv;
    int exp_a[4];
    int ev;
    exp_a = '{254, 255, 0, 1};
    for (int i = 0; i < 256; i++) begin ram_a[i] = '0; ram_b[i] = '0; end
    a_rdata = '0; b_rdata = '0;
    rst = 1'b1; start = 1'b0; len = '0; base_a = '0; base_b = '0;
    bias = '0; res_ready = 1'b0;

    vecs[0] = '{9'd4, 8'd0,  8'd16,  32'd0,   {8'd4, 8'd3, 8'd2, 8'd1},
                {8'd8, 8'd7, 8'd6, 8'd5}, 32'd70, 32'd70, 4'd0};
    vecs[1] = '{9'd2, 8'd32, 8'd48,  32'd0,   {8'd0, 8'd0, 8'h80, 8'h80},
                {8'd0, 8'd0, 8'd127, 8'h80}, 32'd128, 32'd128, 4'd0};
    vecs[2] = '{9'd0, 8'd64, 8'd80,  32'd100, 32'd0, 32'd0, 32'd0, 32'd100, 4'd0};
    vecs[3] = '{9'd3, 8'd96, 8'd112, 32'hFFFF_FFFB, {8'd0, 8'd30, 8'hEC, 8'd10},
                {8'd0, 8'hFF, 8'd3, 8'd3}, 32'hFFFF_FFC4, 32'hFFFF_FFBF, 4'd5};
    vecs[4] = '{9'd1, 8'd128, 8'd144, 32'd1,  {8'd0, 8'd0, 8'd0, 8'd127},
                {8'd0, 8'd0, 8'd0, 8'd127}, 32'd16129, 32'd16130, 4'd0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_mac_en", int'(mac_en), 0);
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_a_addr", int'(a_addr), 0);
    chk("rst_mac_z", int'(mac_z), 0);

    for (int v = 0; v < 5; v++) begin
`ifdef MAC_DOT_SEQ_BIAS_EN
      ev = int'(vecs[v].exp_b);
`else
      ev = int'(vecs[v].exp_nb);
`endif
      run_job(vecs[v].len, vecs[v].base_a, vecs[v].base_b, vecs[v].bias,
              vecs[v].a, vecs[v].b, 32'(ev), int'(vecs[v].hold));
    end

    // Address wrap: A at 254..1, B at 0..3
    av = {8'd1, 8'd1, 8'd1, 8'd1};
    bv = {8'd5, 8'd4, 8'd3, 8'd2};
    run_job(9'd4, 8'd254, 8'd0, 32'd0, av, bv, 32'd14, 0);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_a_addr", (aq.size() > i) ? aq[i] : -1, exp_a[i]);
      chk("wrap_b_addr", (bq.size() > i) ? bq[i] : -1, i);
    end

    // Reset in the second RUN cycle aborts the job
    @(posedge clk); #1;
    start = 1'b1; len = 9'd4; base_a = 8'd0; base_b = 8'd16; bias = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("run_mac_en", int'(mac_en), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_mac_en", int'(mac_en), 0);
    chk("abort_valid", int'(res_valid), 0);
    chk("abort_rd_en", int'(rd_en), 0);

    av = {8'd0, 8'd0, 8'd0, 8'd3};
    bv = {8'd0, 8'd0, 8'd0, 8'hFC};
    run_job(9'd1, 8'd200, 8'd210, 32'd0, av, bv, 32'hFFFF_FFF4, 0);

    repeat (2) @(posedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
